// File: rtl/writeback_stage_if.sv
// Signal bundle between the memory stage and the MEM/WB write-back unit.
// The memory-stage result comes in, and the register-file/CC results go out to decode.
interface writeback_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             stall;
  logic             mem_valid;
  logic             mem_load_regfile;
  logic             mem_load_cc;
  logic             mem_destmux_sel;
  logic [2:0]       mem_dest;
  logic [2:0]       mem_regfilemux_sel;
  logic [WIDTH-1:0] mem_alu_out;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] mem_pc;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] regfilemux_out;
  logic             load_regfile;
  logic [2:0]       destb;
  logic             destmux_sel;
  logic [2:0]       cc_nzp;
  logic             wb_valid;

  modport master (
    output stall, mem_valid, mem_load_regfile, mem_load_cc, mem_destmux_sel, mem_dest,
           mem_regfilemux_sel, mem_alu_out, mem_rdata, mem_pc, mem_addr,
    input  regfilemux_out, load_regfile, destb, destmux_sel, cc_nzp, wb_valid
  );

  modport slave (
    input  stall, mem_valid, mem_load_regfile, mem_load_cc, mem_destmux_sel, mem_dest,
           mem_regfilemux_sel, mem_alu_out, mem_rdata, mem_pc, mem_addr,
    output regfilemux_out, load_regfile, destb, destmux_sel, cc_nzp, wb_valid
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and write-back unit of the pipelined LC-3b: picks the
// register-file write value, drives the write port once per instruction, and keeps NZP.
module writeback_stage #(
  parameter int unsigned WIDTH    = 16,
  parameter logic [2:0]  CC_RESET = 3'b010
) (
  input logic             clk,
  input logic             reset,
  writeback_stage_if.slave wb
);

  logic             r_valid;
  logic             r_written;
  logic             r_load_regfile;
  logic             r_load_cc;
  logic             r_destmux_sel;
  logic [2:0]       r_dest;
  logic [2:0]       r_sel;
  logic [WIDTH-1:0] r_alu_out;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_addr;
  logic [2:0]       r_cc;

  logic [WIDTH-1:0] w_value;
  logic [2:0]       w_nzp;
  logic             w_load_regfile;
  logic             w_cc_update;
  logic             w_commit;

  always_comb begin
    w_value = '0;
    case (r_sel)
      3'd0:    w_value = r_alu_out;
      3'd1:    w_value = r_rdata;
      3'd2:    w_value = {{(WIDTH-8){1'b0}}, (r_addr[0] ? r_rdata[15:8] : r_rdata[7:0])};
      3'd3:    w_value = r_pc;
      3'd4:    w_value = r_addr;
      default: w_value = '0;
    endcase
  end

  always_comb begin
    w_nzp = 3'b001;
    if (w_value[WIDTH-1])    w_nzp = 3'b100;
    else if (w_value == '0)  w_nzp = 3'b010;
  end

  // written blocks repeat regfile/CC writes while a stall holds the same instruction
  assign w_load_regfile = r_valid & r_load_regfile & ~r_written;
  assign w_cc_update    = r_valid & r_load_cc & ~r_written;
  assign w_commit       = w_load_regfile | w_cc_update;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_written      <= 1'b0;
      r_load_regfile <= 1'b0;
      r_load_cc      <= 1'b0;
      r_destmux_sel  <= 1'b0;
      r_dest         <= '0;
      r_sel          <= '0;
      r_alu_out      <= '0;
      r_rdata        <= '0;
      r_pc           <= '0;
      r_addr         <= '0;
      r_cc           <= CC_RESET;
    end else begin
      if (w_cc_update) r_cc <= w_nzp;
      if (!wb.stall) begin
        r_valid        <= wb.mem_valid;
        r_written      <= 1'b0;
        r_load_regfile <= wb.mem_load_regfile;
        r_load_cc      <= wb.mem_load_cc;
        r_destmux_sel  <= wb.mem_destmux_sel;
        r_dest         <= wb.mem_dest;
        r_sel          <= wb.mem_regfilemux_sel;
        r_alu_out      <= wb.mem_alu_out;
        r_rdata        <= wb.mem_rdata;
        r_pc           <= wb.mem_pc;
        r_addr         <= wb.mem_addr;
      end else if (w_commit) begin
        r_written <= 1'b1;
      end
    end
  end

  assign wb.regfilemux_out = w_value;
  assign wb.load_regfile   = w_load_regfile;
  assign wb.destb          = r_dest;
  assign wb.destmux_sel    = r_destmux_sel;
  assign wb.cc_nzp         = r_cc;
  assign wb.wb_valid       = r_valid;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: an instruction-level model is compared every cycle,
// and literal expectations from hand-worked LC-3b cases pin the model.
module tb_writeback_stage;

  logic clk = 1'b0;
  logic reset;

  writeback_stage_if #(.WIDTH(16)) bus ();

  writeback_stage #(.WIDTH(16), .CC_RESET(3'b010)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        load_regfile;
    logic        load_cc;
    logic        destmux_sel;
    logic [2:0]  dest;
    logic [2:0]  sel;
    logic [15:0] alu_out;
    logic [15:0] rdata;
    logic [15:0] pc;
    logic [15:0] addr;
  } inst_t;

  // Model: the instruction sitting in WB, whether it is real, and whether it already wrote.
  inst_t      m_inst;
  logic       m_valid;
  logic       m_done;
  logic [2:0] m_cc;
  bit         m_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  function automatic logic [15:0] result_of(input inst_t i);
    logic [15:0] b;
    b = i.addr[0] ? (i.rdata >> 8) : i.rdata;
    case (i.sel)
      3'd0: return i.alu_out;
      3'd1: return i.rdata;
      3'd2: return {8'h00, b[7:0]};
      3'd3: return i.pc;
      3'd4: return i.addr;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] flags_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000)  return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_inst  = '0;
      m_valid = 1'b0;
      m_done  = 1'b0;
      m_cc    = 3'b010;
      m_ready = 1'b1;
    end else begin
      if (m_valid && !m_done && m_inst.load_cc) m_cc = flags_of(result_of(m_inst));
      if (!bus.stall) begin
        m_inst  = '{bus.mem_load_regfile, bus.mem_load_cc, bus.mem_destmux_sel, bus.mem_dest,
                    bus.mem_regfilemux_sel, bus.mem_alu_out, bus.mem_rdata, bus.mem_pc,
                    bus.mem_addr};
        m_valid = bus.mem_valid;
        m_done  = 1'b0;
      end else if (m_valid) begin
        m_done = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic step();
    @(posedge clk);
    #2;
    if (bus.load_regfile === 1'b1) pulses++;
    if (m_ready) begin
      chk("m_wdata", 32'(bus.regfilemux_out), 32'(m_valid ? result_of(m_inst)
                                                          : result_of(m_inst)));
      chk("m_we", 32'(bus.load_regfile), 32'(m_valid & m_inst.load_regfile & ~m_done));
      chk("m_destb", 32'(bus.destb), 32'(m_inst.dest));
      chk("m_dsel", 32'(bus.destmux_sel), 32'(m_inst.destmux_sel));
      chk("m_cc", 32'(bus.cc_nzp), 32'(m_cc));
      chk("m_valid", 32'(bus.wb_valid), 32'(m_valid));
    end
  endtask

  task automatic drive(input logic v, input logic lrf, input logic lcc, input logic dsel,
                       input logic [2:0] dest, input logic [2:0] sel, input logic [15:0] alu,
                       input logic [15:0] rd, input logic [15:0] pc, input logic [15:0] addr);
    bus.mem_valid          = v;
    bus.mem_load_regfile   = lrf;
    bus.mem_load_cc        = lcc;
    bus.mem_destmux_sel    = dsel;
    bus.mem_dest           = dest;
    bus.mem_regfilemux_sel = sel;
    bus.mem_alu_out        = alu;
    bus.mem_rdata          = rd;
    bus.mem_pc             = pc;
    bus.mem_addr           = addr;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    reset     = 1'b1;
    bus.stall = 1'b1;
    bubble();

    // Reset with stall held: reset wins.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_cc", 32'(bus.cc_nzp), 32'h2);
      chk("rst_valid", 32'(bus.wb_valid), 32'h0);
      chk("rst_we", 32'(bus.load_regfile), 32'h0);
    end
    chk("rst_wdata", 32'(bus.regfilemux_out), 32'h0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    // ADD R3 producing 0x8000.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h8000, 16'h0, 16'h0, 16'h0);
    step();
    chk("add_wdata", 32'(bus.regfilemux_out), 32'h8000);
    chk("add_destb", 32'(bus.destb), 32'h3);
    chk("add_we", 32'(bus.load_regfile), 32'h1);
    bubble();
    step();
    chk("add_cc", 32'(bus.cc_nzp), 32'h4);

    // LDB high byte then low byte.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 16'h0, 16'hAB12, 16'h0, 16'h1001);
    step();
    chk("ldb_hi", 32'(bus.regfilemux_out), 32'h00AB);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 3'd2, 16'h0, 16'hAB12, 16'h0, 16'h1000);
    step();
    chk("ldb_lo", 32'(bus.regfilemux_out), 32'h0012);
    chk("ldb_cc", 32'(bus.cc_nzp), 32'h1);
    bubble();
    step();

    // JSR link to R7, no CC update.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 3'd3, 16'h0, 16'h0, 16'h3002, 16'h0);
    step();
    chk("jsr_wdata", 32'(bus.regfilemux_out), 32'h3002);
    chk("jsr_dsel", 32'(bus.destmux_sel), 32'h1);
    bubble();
    step();
    chk("jsr_cc", 32'(bus.cc_nzp), 32'h1);

    // LDR and LEA select paths.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 16'h0, 16'h7F00, 16'h0, 16'h0);
    step();
    chk("ldr_wdata", 32'(bus.regfilemux_out), 32'h7F00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd4, 16'h0, 16'h0, 16'h0, 16'h4321);
    step();
    chk("lea_wdata", 32'(bus.regfilemux_out), 32'h4321);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 3'd6, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step();
    chk("sel6_wdata", 32'(bus.regfilemux_out), 32'h0);

    // ADD with zero result, then a 3-cycle stall with a different bundle offered.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 3'd0, 16'h0000, 16'h0, 16'h0, 16'h0);
    pulses = 0;
    step();
    chk("stl_we0", 32'(bus.load_regfile), 32'h1);
    bus.stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 3'd0, 16'h1234, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_we", 32'(bus.load_regfile), 32'h0);
      chk("stl_destb", 32'(bus.destb), 32'h5);
      chk("stl_cc", 32'(bus.cc_nzp), 32'h2);
    end
    chk("stl_pulses", 32'(pulses), 32'h1);
    bus.stall = 1'b0;
    bubble();
    step();

    // Bubble carrying load bits must not write.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'd6, 3'd0, 16'h8000, 16'h0, 16'h0, 16'h0);
    step();
    chk("bub_we", 32'(bus.load_regfile), 32'h0);
    bubble();
    step();
    chk("bub_cc", 32'(bus.cc_nzp), 32'h2);

    // Reset arriving together with a stall on a fresh ADD discards it.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h8000, 16'h0, 16'h0, 16'h0);
    step();
    chk("rs_we0", 32'(bus.load_regfile), 32'h1);
    bus.stall = 1'b1;
    reset     = 1'b1;
    step();
    chk("rs_valid", 32'(bus.wb_valid), 32'h0);
    chk("rs_we", 32'(bus.load_regfile), 32'h0);
    chk("rs_cc", 32'(bus.cc_nzp), 32'h2);
    reset     = 1'b0;
    bus.stall = 1'b0;
    bubble();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
